// File: rtl/crc_chan_sched_if.sv
// Bundles the requester, result and engine signals of crc_chan_sched.
// slave  : the scheduler's view (requester side in, engine requests out)
// master : the environment's view (requesters, result consumers, CRC engine)
interface crc_chan_sched_if #(
  parameter int N = 2
);
  // requester side
  logic [N-1:0]    ch_start;
  logic [N-1:0]    ch_init_ones;
  logic [N-1:0]    ch_refout;
  logic [N-1:0]    ch_xorout;
  logic [N-1:0]    ch_valid;
  logic [N-1:0]    ch_last;
  logic [8*N-1:0]  ch_data;
  logic [N-1:0]    ch_ready;

  // result side
  logic [N-1:0]    res_valid;
  logic [32*N-1:0] res_crc;
  logic [N-1:0]    res_ack;
  logic [N-1:0]    err;

  // shared CRC engine
  logic            eng_start;
  logic [7:0]      eng_din;
  logic [31:0]     eng_crc_in;
  logic            eng_done;
  logic [31:0]     eng_crc_out;

  modport slave (
    input  ch_start, ch_init_ones, ch_refout, ch_xorout,
    input  ch_valid, ch_last, ch_data, res_ack,
    input  eng_done, eng_crc_out,
    output ch_ready, res_valid, res_crc, err,
    output eng_start, eng_din, eng_crc_in
  );

  modport master (
    output ch_start, ch_init_ones, ch_refout, ch_xorout,
    output ch_valid, ch_last, ch_data, res_ack,
    output eng_done, eng_crc_out,
    input  ch_ready, res_valid, res_crc, err,
    input  eng_start, eng_din, eng_crc_in
  );
endinterface

// File: rtl/crc_chan_sched.sv
// Round-robin scheduler sharing one byte-wise CRC32 engine between N
// requester channels. Each channel keeps its own CRC context and output
// configuration; the final reflection/XOR is applied on the last byte.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | look for an eligible channel, grant it and capture its byte
// ISSUE  | one-cycle eng_start with captured byte and channel context
// WAIT   | wait for eng_done (write back) or timeout (abort channel)
module crc_chan_sched #(
  parameter int N           = 2,
  parameter int ENG_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  crc_chan_sched_if.slave    bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(ENG_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[31-b];
    return r;
  endfunction

  // FSM and in-flight transaction registers
  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     g_q, g_d;
  logic [7:0]        byte_q, byte_d;
  logic              last_q, last_d;
  logic [31:0]       crc_in_q, crc_in_d;
  logic              kill_q, kill_d;
  logic [TW-1:0]     tmr_q, tmr_d;

  // per-channel state
  logic [N-1:0]          active_q;
  logic [N-1:0][31:0]    ctx_q;
  logic [N-1:0]          refout_q;
  logic [N-1:0]          xorout_q;
  logic [N-1:0]          res_valid_q;
  logic [N-1:0][31:0]    res_crc_q;
  logic [N-1:0]          err_q;

  // combinational helpers
  logic [N-1:0]      eligible;
  logic              rr_found;
  logic [PW-1:0]     rr_idx;
  logic [PW:0]       rr_sum;
  logic [N-1:0]      ch_ready_c;
  logic              eng_start_c;
  logic              wb_c;
  logic              to_c;
  logic [31:0]       fin_crc;

  // A start in the same cycle as a byte takes effect first; the byte waits a cycle.
  assign eligible = active_q & bus.ch_valid & ~res_valid_q & ~bus.ch_start;

  // Pick the first eligible channel at or after the round-robin pointer.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = 0; k < N; k++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(N)) rr_sum = rr_sum - (PW+1)'(N);
      if (!rr_found && eligible[rr_sum[PW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[PW-1:0];
      end
    end
  end

  // Final CRC of the in-flight channel as it would be stored on its last byte.
  always_comb begin
    fin_crc = refout_q[g_q] ? bitrev32(bus.eng_crc_out) : bus.eng_crc_out;
    if (xorout_q[g_q]) fin_crc = fin_crc ^ 32'hFFFF_FFFF;
  end

  // FSM next-state and transaction bookkeeping.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    byte_d      = byte_q;
    last_d      = last_q;
    crc_in_d    = crc_in_q;
    kill_d      = kill_q;
    tmr_d       = tmr_q;
    ch_ready_c  = '0;
    eng_start_c = 1'b0;
    wb_c        = 1'b0;
    to_c        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          ch_ready_c[rr_idx] = 1'b1;
          g_d      = rr_idx;
          byte_d   = bus.ch_data[{rr_idx, 3'b000} +: 8];
          last_d   = bus.ch_last[rr_idx];
          crc_in_d = ctx_q[rr_idx];
          kill_d   = 1'b0;
          ptr_d    = (rr_idx == PW'(N-1)) ? '0 : rr_idx + 1'b1;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        eng_start_c = 1'b1;
        tmr_d       = TW'(ENG_TIMEOUT);
        if (bus.ch_start[g_q]) kill_d = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (bus.ch_start[g_q]) kill_d = 1'b1;
        if (bus.eng_done) begin
          // A restarted channel still consumes the engine result but ignores it.
          wb_c    = !kill_q;
          state_d = S_IDLE;
        end else if (tmr_q == TW'(1)) begin
          to_c    = !kill_q;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FSM and in-flight transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      crc_in_q <= '0;
      kill_q   <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      crc_in_q <= crc_in_d;
      kill_q   <= kill_d;
      tmr_q    <= tmr_d;
    end
  end

  // Per-channel context/result state; priority: start > result/abort > ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= '0;
      ctx_q       <= '0;
      refout_q    <= '0;
      xorout_q    <= '0;
      res_valid_q <= '0;
      res_crc_q   <= '0;
      err_q       <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.res_ack[i]) res_valid_q[i] <= 1'b0;

        if (bus.ch_start[i]) begin
          active_q[i]    <= 1'b1;
          ctx_q[i]       <= bus.ch_init_ones[i] ? 32'hFFFF_FFFF : 32'h0000_0000;
          refout_q[i]    <= bus.ch_refout[i];
          xorout_q[i]    <= bus.ch_xorout[i];
          res_valid_q[i] <= 1'b0;
          err_q[i]       <= 1'b0;
        end else if (wb_c && (g_q == PW'(i))) begin
          ctx_q[i] <= bus.eng_crc_out;
          if (last_q) begin
            res_crc_q[i]   <= fin_crc;
            res_valid_q[i] <= 1'b1;
            active_q[i]    <= 1'b0;
          end
        end else if (to_c && (g_q == PW'(i))) begin
          err_q[i]    <= 1'b1;
          active_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.ch_ready   = ch_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_crc    = res_crc_q;
  assign bus.err        = err_q;
  assign bus.eng_start  = eng_start_c;
  assign bus.eng_din    = byte_q;
  assign bus.eng_crc_in = crc_in_q;

endmodule
